// File: rtl/pwm_audio_pkg.sv
// rtl/pwm_audio_pkg.sv - shared types and helpers for the PWM audio squelch stage
package pwm_audio_pkg;

  typedef enum logic [1:0] {
    MUTED = 2'd0,
    OPEN  = 2'd1,
    HOLD  = 2'd2
  } squelch_state_t;

  function automatic int unsigned midscale(input int unsigned dw);
    return 32'd1 << (dw - 1);
  endfunction

endpackage

// File: rtl/squelch_fsm.sv
// rtl/squelch_fsm.sv - RSSI hysteresis squelch with programmable hold before muting
module squelch_fsm
  import pwm_audio_pkg::*;
#(
  parameter int RW = 32,
  parameter int HW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [RW-1:0] i_rssi,
  input  logic          i_rssi_valid,
  input  logic [RW-1:0] i_open_thr,
  input  logic [RW-1:0] i_close_thr,
  input  logic [HW-1:0] i_hold_cycles,
  output logic          o_squelch_open
);

  squelch_state_t r_state, w_state_nxt;
  logic [HW-1:0]  r_hold, w_hold_nxt;
  logic           w_above_open, w_below_close, w_hold_exp;

  assign w_above_open  = i_rssi_valid && (i_rssi >= i_open_thr);
  assign w_below_close = i_rssi_valid && (i_rssi <  i_close_thr);
  assign w_hold_exp    = (r_hold == i_hold_cycles - HW'(1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= MUTED;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    case (r_state)
      MUTED: if (w_above_open) w_state_nxt = OPEN;
      OPEN: begin
        if (w_below_close) begin
          w_state_nxt = (i_hold_cycles == '0) ? MUTED : HOLD;
          w_hold_nxt  = '0;
        end
      end
      HOLD: begin
        w_hold_nxt = r_hold + HW'(1);
        // A fresh strong reading takes priority over an expiring hold.
        if (i_rssi_valid && (i_rssi >= i_close_thr)) w_state_nxt = OPEN;
        else if (w_hold_exp)                         w_state_nxt = MUTED;
      end
      default: w_state_nxt = MUTED;
    endcase
  end

  assign o_squelch_open = (r_state != MUTED);

endmodule

// File: rtl/pwm_audio_squelch.sv
// rtl/pwm_audio_squelch.sv - multi-channel double-buffered PWM audio output with squelch mute
module pwm_audio_squelch
  import pwm_audio_pkg::*;
#(
  parameter int CH = 2,
  parameter int DW = 8,
  parameter int RW = 32,
  parameter int HW = 16
) (
  input  logic           oscclk,
  input  logic           rst,
  input  logic           pwm_enable,
  input  logic [RW-1:0]  rssi,
  input  logic           rssi_valid,
  input  logic [RW-1:0]  open_thr,
  input  logic [RW-1:0]  close_thr,
  input  logic [HW-1:0]  hold_cycles,
  input  logic [CH*DW-1:0] sample_in,
  input  logic           sample_valid,
  output logic           sample_ready,
  output logic [CH-1:0]  pwm_out,
  output logic           squelch_open,
  output logic           frame_strobe
);

  localparam logic [DW-1:0] MID     = DW'(midscale(DW));
  localparam logic [DW-1:0] CNT_MAX = '1;

  logic [DW-1:0] r_cnt;
  logic          r_shadow_full, r_mute, r_frame;
  logic          w_wrap, w_accept, w_open;

  assign w_wrap       = (r_cnt == CNT_MAX);
  assign sample_ready = ~r_shadow_full & ~rst;
  assign w_accept     = sample_valid & sample_ready;
  assign squelch_open = w_open;
  assign frame_strobe = r_frame;

  squelch_fsm #(.RW(RW), .HW(HW)) u_squelch (
    .i_clk          (oscclk),
    .i_rst          (rst),
    .i_rssi         (rssi),
    .i_rssi_valid   (rssi_valid),
    .i_open_thr     (open_thr),
    .i_close_thr    (close_thr),
    .i_hold_cycles  (hold_cycles),
    .o_squelch_open (w_open)
  );

  // Mute is latched only at wrap so a period is never cut short.
  always_ff @(posedge oscclk) begin
    if (rst) begin
      r_cnt         <= '0;
      r_shadow_full <= 1'b0;
      r_mute        <= 1'b1;
      r_frame       <= 1'b0;
    end else begin
      r_cnt   <= pwm_enable ? r_cnt + DW'(1) : '0;
      r_frame <= w_wrap;
      if (w_wrap) r_mute <= ~w_open;
      if (w_wrap)        r_shadow_full <= 1'b0;
      else if (w_accept) r_shadow_full <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    logic [DW-1:0] w_sample, w_eff_duty;
    logic [DW-1:0] r_shadow, r_duty;
    logic          r_pwm;

    assign w_sample   = sample_in[gi*DW +: DW];
    assign w_eff_duty = r_mute ? MID : r_duty;
    assign pwm_out[gi] = r_pwm;

    always_ff @(posedge oscclk) begin
      if (rst) begin
        r_shadow <= '0;
        r_duty   <= MID;
        r_pwm    <= 1'b0;
      end else begin
        if (w_accept && !w_wrap) r_shadow <= w_sample;
        if (w_wrap) begin
          if (r_shadow_full) r_duty <= r_shadow;
          else if (w_accept) r_duty <= w_sample;
        end
        r_pwm <= pwm_enable & (r_cnt < w_eff_duty);
      end
    end
  end

endmodule

// File: doc/pwm_audio_squelch.md
# pwm_audio_squelch

Parametrised multi-channel PWM audio output stage with RSSI-driven squelch. It is the successor to the single-channel baseband PWM path. The MCU or baseband DSP streams per-channel samples through a valid/ready handshake. The block produces glitch-free PWM per channel and mutes to midscale silence when RSSI falls below a hysteresis window for longer than a programmable hold time. It sits between the baseband demodulator and the ANALOG/audio pins; thresholds and enable come from the MCU register interface.

## Interface
- CH, 2, number of audio channels
- DW, 8, sample width; PWM period is 2^DW cycles
- RW, 32, RSSI and threshold width
- HW, 16, hold-counter width
- oscclk  in  1  single clock for all logic
- rst  in  1  synchronous, active-high reset
- pwm_enable  in  1  1 = run PWM; 0 = counter held at 0, pwm_out low
- rssi  in  RW  unsigned signal strength
- rssi_valid  in  1  qualifies rssi for one cycle
- open_thr  in  RW  squelch opens when rssi >= open_thr
- close_thr  in  RW  squelch starts closing when rssi < close_thr
- hold_cycles  in  HW  cycles spent in HOLD before muting
- sample_in  in  CH*DW  unsigned offset-binary samples; channel i in bits [i*DW +: DW]
- sample_valid  in  1  sample word offered
- sample_ready  out  1  shadow buffer empty; sample accepted when valid & ready
- pwm_out  out  CH  registered PWM outputs
- squelch_open  out  1  high in OPEN and HOLD
- frame_strobe  out  1  one-cycle pulse on the last count of each PWM period

## Operation
- Counter cnt (DW bits) increments while pwm_enable=1 and wraps from 2^DW-1 to 0. A wrap cycle is a cycle with cnt = 2^DW-1.
- Per-channel path: one shadow register plus one active duty register. A single shadow_full flag covers all channels. sample_ready = ~shadow_full, and is 0 while rst is high.
- On an accept (valid & ready), the shadow register loads and shadow_full is set.
- On a wrap cycle with shadow_full=1, duty loads from shadow and shadow_full is cleared.
- On a wrap cycle with shadow_full=0, duty keeps its previous value. There is no underflow error; the last sample repeats.
- If an accept and a wrap fall in the same cycle with the shadow empty, the sample bypasses into duty directly and the shadow stays empty.
- Effective duty: duty[i] when the frame mute flag is 0, otherwise midscale 2^(DW-1). The mute flag is sampled from squelch state only at wrap, so mute and unmute never truncate a period.
- Output: pwm_out[i] = pwm_enable & (cnt < eff_duty[i]). Duty 0 gives a constant low; duty 2^DW-1 is high for 2^DW-1 of 2^DW cycles.
- Squelch FSM states are MUTED, OPEN and HOLD. It runs regardless of pwm_enable.
  - MUTED -> OPEN: rssi_valid & rssi >= open_thr.
  - OPEN -> HOLD: rssi_valid & rssi < close_thr. The hold counter clears.
  - HOLD -> OPEN: rssi_valid & rssi >= close_thr.
  - HOLD -> MUTED: the hold counter reaches hold_cycles-1. With hold_cycles=0, OPEN goes directly to MUTED in place of HOLD.
  - If a rssi_valid cycle coincides with hold expiry, the rssi comparison wins.
- pwm_enable falling mid-frame: cnt resets to 0 and pwm_out goes low on the next cycle. The shadow, duty and FSM are retained.
- pwm_enable rising: the first period begins at cnt=0 with the retained duty.

## Timing
- Reset values: cnt=0, duty=midscale, shadow_full=0, state=MUTED, mute flag=1, pwm_out=0, squelch_open=0, frame_strobe=0, sample_ready=0. sample_ready is 1 on the first cycle after rst falls.
- pwm_out is registered and lags cnt by 1 cycle.
- frame_strobe is registered, high in the cycle after cnt = 2^DW-1.
- An accepted sample reaches pwm_out at the next wrap plus 1 cycle. Worst-case latency is 2^DW+1 cycles.
- squelch_open updates 1 cycle after the transition condition.
- The audible mute/unmute takes effect in the first period after the next wrap.
- Threshold inputs are sampled every cycle and need no handshake.

## Structure
- Package pwm_audio_pkg:
  - squelch_state_t enum: MUTED=2'd0, OPEN=2'd1, HOLD=2'd2.
  - midscale(DW) constant function.
- Sub-module squelch_fsm: the state register, hold counter and comparators, with squelch_open as its output.
- Top level: counter, shadow/duty arrays generated per channel, and the output registers.

## Test plan
All scenarios use DW=8 and CH=2.
- **Reset and idle:** rst high 3 cycles, then pwm_enable=1 with no samples -> both pwm_out show 128 high of 256 per period; squelch_open=0; sample_ready=1.
- **Sample path:** open squelch (open_thr=100, rssi=150 valid), then send channel0=0x40 and channel1=0xFF -> after the next wrap, channel0 is high 64 cycles and channel1 high 255 cycles per period; sample_ready is low until that wrap.
- **Bypass:** sample_valid asserted exactly on a wrap cycle with the shadow empty -> the new duty appears in the immediately following period; sample_ready stays 1.
- **Hysteresis:** open_thr=100, close_thr=80, hold_cycles=10; rssi sequence 90, 110, 90, 70 -> OPEN only after 110; still OPEN at 90; HOLD at 70; MUTED 10 cycles later; outputs return to midscale at the next wrap.
- **Hold abort and hold=0:** in HOLD, rssi=85 before expiry -> state returns to OPEN. With hold_cycles=0, rssi=70 -> MUTED in 1 cycle.
- **Enable drop:** pwm_enable low at cnt=37 -> pwm_out=0 next cycle; re-enable -> the period restarts from cnt=0 with the retained duty.
